// File: rtl/tagged_flux_fifo_if.sv
// Handshake bundle for tagged_flux_fifo: tagged token in, shared head word out,
// per-flux empty/read lanes, per-flux occupancy and sticky error flags.
interface tagged_flux_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int DEPTH      = 4
);
  localparam int TAG_W = $clog2(FLUX);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [DATA_WIDTH+TAG_W-1:0] din;
  logic                        write;
  logic                        full;
  logic [DATA_WIDTH+TAG_W-1:0] dout;
  logic [FLUX-1:0]             read;
  logic [FLUX-1:0]             empty;
  logic [FLUX*CW-1:0]          occ;
  logic [2:0]                  err;

  modport master (
    output din, write, read,
    input  full, dout, empty, occ, err
  );

  modport slave (
    input  din, write, read,
    output full, dout, empty, occ, err
  );
endinterface

// File: rtl/tagged_flux_fifo.sv
// Single-stream FIFO of tagged tokens; the head entry's tag decides which
// flux sees a non-empty lane and may pop it.
module tagged_flux_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int DEPTH      = 4
) (
  input logic               clk,
  input logic               rst,
  tagged_flux_fifo_if.slave bus
);
  localparam int TAG_W = $clog2(FLUX);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int W     = DATA_WIDTH + TAG_W;
  localparam logic [TAG_W:0] FLUX_L  = (TAG_W + 1)'(FLUX);
  localparam logic [PW:0]    DEPTH_L = (PW + 1)'(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic            r_full;
  logic [CW-1:0]   r_occ [FLUX];
  logic [2:0]      r_err;

  logic [TAG_W-1:0] w_in_tag;
  logic [TAG_W-1:0] w_head_tag;
  logic             w_tag_ok;
  logic [FLUX-1:0]  w_empty;
  logic             w_push;
  logic             w_pop;
  logic [PW:0]      w_count_nxt;
  logic [FLUX-1:0]  w_inc;
  logic [FLUX-1:0]  w_dec;

  always_comb begin
    w_in_tag   = bus.din[W-1:DATA_WIDTH];
    w_head_tag = r_mem[r_rd_ptr][W-1:DATA_WIDTH];
    w_tag_ok   = ({1'b0, w_in_tag} < FLUX_L);
    for (int f = 0; f < FLUX; f++) begin
      w_empty[f] = (r_count == '0) || (w_head_tag != TAG_W'(f));
    end
    w_push = bus.write && !r_full && w_tag_ok;
    // Only the head's lane can be non-empty, so any read on a live lane is the pop.
    w_pop  = |(bus.read & ~w_empty);
    w_count_nxt = r_count + (PW + 1)'(w_push) - (PW + 1)'(w_pop);
    for (int f = 0; f < FLUX; f++) begin
      w_inc[f] = w_push && (w_in_tag == TAG_W'(f));
      w_dec[f] = w_pop && (w_head_tag == TAG_W'(f));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      for (int f = 0; f < FLUX; f++) r_occ[f] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_err    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_L);
      for (int f = 0; f < FLUX; f++) begin
        case ({w_inc[f], w_dec[f]})
          2'b10:   r_occ[f] <= r_occ[f] + CW'(1);
          2'b01:   r_occ[f] <= r_occ[f] - CW'(1);
          default: r_occ[f] <= r_occ[f];
        endcase
      end
      r_err[0] <= r_err[0] | (bus.write & r_full);
      r_err[1] <= r_err[1] | (|(bus.read & w_empty));
      r_err[2] <= r_err[2] | (bus.write & ~r_full & ~w_tag_ok);
    end
  end

  always_comb begin
    bus.dout  = r_mem[r_rd_ptr];
    bus.empty = w_empty;
    bus.full  = r_full;
    bus.err   = r_err;
    bus.occ   = '0;
    for (int f = 0; f < FLUX; f++) begin
      bus.occ[f*CW +: CW] = r_occ[f];
    end
  end
endmodule
